// File: rtl/rip_load_store_unit.sv
// -----------------------------------------------------------------------------
// rip_load_store_unit
//
// Load/store unit between the memory stage of the pipeline and data port 1 of
// the memory control unit. It accepts one RV32I load or store per handshake.
// Byte addresses become word addresses plus a 4-bit byte-write mask. Loads
// follow the memory's re/busy protocol, and the read word is aligned and then
// sign- or zero-extended. Each request produces a single-cycle response pulse.
//
// Optional feature macro: RIP_LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned halfword or word access completes with resp_err_o=1
//               and makes no memory access.
//   undefined : the misaligned low address bits are ignored.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rstn_i         asynchronous active-low reset
//   req_valid_i    request valid from the pipeline
//   req_ready_o    high only in IDLE while mem_busy_i is low
//   req_we_i       1 = store, 0 = load
//   req_funct3_i   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr_i     byte address
//   req_wdata_i    store data, LSB-justified
//   resp_valid_o   one-cycle completion pulse
//   resp_rdata_o   extended load data; 0 for stores and errors
//   resp_err_o     error flag qualified by resp_valid_o
//   mem_re_o       one-cycle read strobe
//   mem_we_o       byte-write mask, one cycle
//   mem_addr_o     word address (req_addr_i >> 2), held between accesses
//   mem_din_o      store data replicated across byte lanes
//   mem_dout_i     read data, valid when mem_busy_i falls
//   mem_busy_i     memory read in progress
// -----------------------------------------------------------------------------
module rip_load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_re_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i,
  input  logic                  mem_busy_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q;

  // Latched request attributes needed after the accept cycle.
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;

  // Registered outputs.
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  mem_re_q;
  logic [3:0]            mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;

  // Combinational decode of the incoming request.
  logic                  accept;
  logic                  illegal_funct3;
  logic                  misaligned;
  logic                  req_err;
  logic [1:0]            off_d;
  logic [3:0]            mem_we_d;
  logic [DATA_WIDTH-1:0] mem_din_d;

  // Load alignment and extension.
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] load_data_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Gating with mem_busy_i keeps a new request out while a read abandoned by a
  // reset is still draining inside the memory.
  assign req_ready_o = rstn_i && (state_q == ST_IDLE) && !mem_busy_i;
  assign accept      = req_valid_i && req_ready_o;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal_funct3 = 1'b0;
    if (req_we_i) begin
      // Only SB/SH/SW (000/001/010) exist for stores.
      illegal_funct3 = req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11);
    end else begin
      // Loads: 011, 110 and 111 are not defined.
      illegal_funct3 = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
  end

`ifdef RIP_LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = illegal_funct3 || misaligned;

  // Effective byte offset inside the word. Address bits below the access size
  // are dropped, so an untrapped misaligned access behaves as the aligned one.
  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   off_d = req_addr_i[1:0];
      2'b01:   off_d = {req_addr_i[1], 1'b0};
      default: off_d = 2'b00;
    endcase
  end

  // Store mask and lane-replicated data. Replication lets the memory take
  // any lane from mem_din_o without shifting.
  always_comb begin
    mem_we_d  = 4'b0000;
    mem_din_d = '0;
    case (req_funct3_i[1:0])
      2'b00: begin
        mem_we_d  = 4'b0001 << off_d;
        mem_din_d = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        mem_we_d  = 4'b0011 << off_d;
        mem_din_d = {2{req_wdata_i[15:0]}};
      end
      default: begin
        mem_we_d  = 4'b1111;
        mem_din_d = req_wdata_i;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  assign lane_data = mem_dout_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_data_d = {{24{lane_data[7]}},  lane_data[7:0]};
      3'b001:  load_data_d = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data_d = {24'd0, lane_data[7:0]};
      3'b101:  load_data_d = {16'd0, lane_data[15:0]};
      default: load_data_d = lane_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            off_q    <= off_d;
            if (req_err) begin
              // Errors skip ISSUE entirely, so the memory is never touched
              // and mem_addr_o keeps its previous value.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              // The memory strobes are loaded here so that they are visible
              // for exactly the ISSUE cycle.
              state_q    <= ST_ISSUE;
              mem_addr_q <= {2'b00, req_addr_i[ADDR_WIDTH-1:2]};
              if (req_we_i) begin
                mem_we_q  <= mem_we_d;
                mem_din_q <= mem_din_d;
              end else begin
                mem_re_q  <= 1'b1;
              end
            end
          end
        end

        ST_ISSUE: begin
          mem_re_q  <= 1'b0;
          mem_we_q  <= 4'b0000;
          mem_din_q <= '0;
          if (we_q) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // The memory raises busy the cycle after the strobe. The first
          // cycle with busy low carries valid read data.
          if (!mem_busy_i) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data_d;
          end
        end

        ST_RESP: begin
          // resp_rdata_o and resp_err_o keep their values until the next
          // response.
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;

endmodule
